uart_tx_arbiter: RTL

// Shares one uart_tx instance between NUM_REQ byte requesters using round-robin arbitration.

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte requesters, the uart_tx transmitter and the round-robin arbiter.
// slave is the arbiter's view; master is the view of the clients plus the transmitter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int OWNER_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] data;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         tx_data;
    logic                      send_data;
    logic                      tx_busy;
    logic [OWNER_W-1:0]        owner;
    logic                      busy;
    logic                      timeout_err;

    modport slave (
        input  req, data, lock, tx_busy,
        output ack, tx_data, send_data, owner, busy, timeout_err
    );

    modport master (
        output req, data, lock, tx_busy,
        input  ack, tx_data, send_data, owner, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte requesters.
// Define UART_TX_LOCK_EN to let a locked owner send back-to-back bytes without re-arbitration.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_tx_arbiter_if.slave    bus
);
    localparam int OWNER_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t             state;
    logic [OWNER_W-1:0] rr_ptr;
    logic [OWNER_W-1:0] winner;
    logic [OWNER_W-1:0] idx;
    logic               found;
    logic [7:0]         start_cnt;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        winner = rr_ptr;
        idx    = rr_ptr;
        found  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = OWNER_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

`ifndef UART_TX_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^bus.lock;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rr_ptr          <= OWNER_W'(NUM_REQ - 1);
            start_cnt       <= '0;
            bus.ack         <= '0;
            bus.tx_data     <= '0;
            bus.send_data   <= 1'b0;
            bus.owner       <= '0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.ack         <= '0;
            bus.send_data   <= 1'b0;
            bus.timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.tx_data   <= bus.data[int'(winner)*DATA_W +: DATA_W];
                        bus.owner     <= winner;
                        rr_ptr        <= winner;
                        bus.ack       <= NUM_REQ'(1) << winner;
                        bus.send_data <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    start_cnt <= '0;
                    state     <= WAIT_START;
                end
                WAIT_START: begin
                    // A launch that never starts a frame is dropped; the byte was already acked.
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (start_cnt == 8'(START_TIMEOUT - 1)) begin
                        bus.timeout_err <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        start_cnt <= start_cnt + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
`ifdef UART_TX_LOCK_EN
                        if (bus.lock[bus.owner] && bus.req[bus.owner]) begin
                            bus.tx_data   <= bus.data[int'(bus.owner)*DATA_W +: DATA_W];
                            bus.ack       <= NUM_REQ'(1) << bus.owner;
                            bus.send_data <= 1'b1;
                            state         <= LAUNCH;
                        end else begin
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end
`else
                        bus.busy <= 1'b0;
                        state    <= IDLE;
`endif
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
